// File: rtl/toy_pkg.sv
// rtl/toy_pkg.sv - widths, panel states and button priority shared by the TOY front panel
package toy_pkg;

  localparam int ADDR_W  = 8;
  localparam int WORD_W  = 16;
  localparam int NUM_BTN = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM,
    ST_STEP,
    ST_RUN,
    ST_STOPPING
  } panel_state_e;

  // Button index doubles as priority: the lowest index wins when pulses coincide.
  typedef enum int {
    BTN_STOP  = 0,
    BTN_LOAD  = 1,
    BTN_LOOK  = 2,
    BTN_STEP  = 3,
    BTN_RUN   = 4,
    BTN_ENTER = 5
  } btn_idx_e;

  function automatic logic [NUM_BTN-1:0] btn_winner(input logic [NUM_BTN-1:0] p);
    logic [NUM_BTN-1:0] w;
    w = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (p[i]) begin
        w    = '0;
        w[i] = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stable-level counter and rising-edge pulse for one button
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      pulse  <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        pulse   <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/panel_ctrl.sv
// rtl/panel_ctrl.sv - TOY front-panel sequencer: LOAD/LOOK on the rw port, step/run/stop, stdin entry
// Optional feature macro: PANEL_AUTOINC_EN (post-incrementing panel address register).
module panel_ctrl
  import toy_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_load_i,
  input  logic              btn_look_i,
  input  logic              btn_step_i,
  input  logic              btn_run_i,
  input  logic              btn_stop_i,
  input  logic              btn_enter_i,
  input  logic [ADDR_W-1:0] sw_addr_i,
  input  logic [WORD_W-1:0] sw_data_i,
  output logic              mem_val_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  input  logic              mem_rdy_i,
  output logic              panel_owns_mem_o,
  output logic              cpu_exec_o,
  input  logic              cpu_running_i,
  input  logic              instr_val_i,
  input  logic              in_req_i,
  output logic              in_val_o,
  output logic [WORD_W-1:0] in_data_o,
  input  logic              in_rdy_i,
  output logic [ADDR_W-1:0] disp_addr_o,
  output logic [WORD_W-1:0] disp_data_o,
  output logic              led_ready_o,
  output logic              led_inwait_o
);

  logic [NUM_BTN-1:0] btn_raw, pulse, win;

  assign btn_raw = {btn_enter_i, btn_run_i, btn_step_i, btn_look_i, btn_load_i, btn_stop_i};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_raw[gi]),
      .pulse (pulse[gi])
    );
  end

  assign win = btn_winner(pulse);

  panel_state_e      state_q, state_d;
  logic              step_first_q, running_q;
  logic              mem_wen_q, in_val_q;
  logic [ADDR_W-1:0] mem_addr_q, disp_addr_q, base_addr;
  logic [WORD_W-1:0] mem_wdata_q, disp_data_q, in_data_q;

`ifdef PANEL_AUTOINC_EN
  logic [ADDR_W-1:0] inc_addr_q, sw_last_q;
  logic              sw_changed;

  // A moved address switch always overrides the incremented address.
  assign sw_changed = (sw_addr_i != sw_last_q);
  assign base_addr  = sw_changed ? sw_addr_i : inc_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_addr_q <= '0;
      sw_last_q  <= '0;
    end else begin
      sw_last_q <= sw_addr_i;
      if (sw_changed) begin
        inc_addr_q <= sw_addr_i;
      end else if (state_q == ST_MEM && mem_rdy_i) begin
        inc_addr_q <= mem_addr_q + ADDR_W'(1);
      end
    end
  end
`else
  assign base_addr = sw_addr_i;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win[BTN_LOAD] || win[BTN_LOOK]) state_d = ST_MEM;
        else if (win[BTN_STEP])             state_d = ST_STEP;
        else if (win[BTN_RUN])              state_d = ST_RUN;
      end
      ST_MEM:      if (mem_rdy_i)   state_d = ST_IDLE;
      ST_STEP:     if (instr_val_i) state_d = ST_IDLE;
      ST_RUN: begin
        if (win[BTN_STOP])                     state_d = ST_STOPPING;
        else if (running_q && !cpu_running_i)  state_d = ST_IDLE;
      end
      ST_STOPPING: if (!cpu_running_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      step_first_q <= 1'b0;
      running_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      disp_addr_q  <= '0;
      disp_data_q  <= '0;
      in_val_q     <= 1'b0;
      in_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      running_q    <= cpu_running_i;
      step_first_q <= (state_q == ST_IDLE) && (state_d == ST_STEP);
      if (state_q == ST_IDLE && state_d == ST_MEM) begin
        mem_addr_q  <= base_addr;
        mem_wdata_q <= sw_data_i;
        mem_wen_q   <= win[BTN_LOAD];
      end
      if (state_q == ST_MEM && mem_rdy_i) begin
        disp_addr_q <= mem_addr_q;
        disp_data_q <= mem_wen_q ? mem_wdata_q : mem_rdata_i;
      end
      if (in_val_q && in_rdy_i) begin
        in_val_q <= 1'b0;
      end else if (!in_val_q && win[BTN_ENTER] && led_inwait_o) begin
        in_val_q  <= 1'b1;
        in_data_q <= sw_data_i;
      end
    end
  end

  assign mem_val_o        = (state_q == ST_MEM);
  assign mem_wen_o        = mem_val_o && mem_wen_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign panel_owns_mem_o = (state_q == ST_IDLE) || (state_q == ST_MEM);
  assign cpu_exec_o       = (state_q == ST_RUN) || (state_q == ST_STEP && step_first_q);
  assign in_val_o         = in_val_q;
  assign in_data_o        = in_data_q;
  assign disp_addr_o      = disp_addr_q;
  assign disp_data_o      = disp_data_q;
  assign led_ready_o      = (state_q == ST_IDLE);
  assign led_inwait_o     = in_req_i && (state_q == ST_RUN);

endmodule
